// File: rtl/piso_serializer_if.sv
// piso_serializer_if: word handshake in, framed serial stream out
// master: word source and stream sink; slave: the serializer
// din/din_valid/din_ready: parallel word handshake
// sdo/sdo_valid/sof/done: serial bit, bit qualifier, first-bit and last-bit markers
interface piso_serializer_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] din;
  logic din_valid;
  logic din_ready;
  logic sdo;
  logic sdo_valid;
  logic sof;
  logic done;
  modport master (output din, din_valid, input din_ready, sdo, sdo_valid, sof, done);
  modport slave (input din, din_valid, output din_ready, sdo, sdo_valid, sof, done);
endinterface

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in serial-out transmitter, LSB first, with sof/done frame markers
// clk: rising-edge clock; reset_n: asynchronous active-low reset
// bus (slave): din/din_valid/din_ready handshake in, sdo/sdo_valid/sof/done stream out
// PISO_PARITY_EN: appends an even-parity bit after the data bits
module piso_serializer #(
  parameter int WIDTH = 4,
  parameter int GAP_CYCLES = 0
) (
  input logic clk,
  input logic reset_n,
  piso_serializer_if.slave bus
);
`ifdef PISO_PARITY_EN
  localparam int N = WIDTH + 1;
`else
  localparam int N = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
  state_t state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0] cnt;
  logic [7:0] gcnt;
  logic sdo_r, valid_r, sof_r, done_r, ready_r;
`ifdef PISO_PARITY_EN
  logic par;
`endif
  logic accept, last;
  // ready_r is only high in IDLE or on the last bit when streaming, so accept covers both load paths
  assign accept = bus.din_valid && ready_r;
  assign last = cnt == CW'(N - 1);
  assign bus.din_ready = ready_r;
  assign bus.sdo = sdo_r;
  assign bus.sdo_valid = valid_r;
  assign bus.sof = sof_r;
  assign bus.done = done_r;
  // shreg holds the bits still to be sent; the bit on sdo has already been moved out
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      shreg <= '0;
      cnt <= '0;
      gcnt <= '0;
      sdo_r <= 1'b0;
      valid_r <= 1'b0;
      sof_r <= 1'b0;
      done_r <= 1'b0;
      ready_r <= 1'b1;
`ifdef PISO_PARITY_EN
      par <= 1'b0;
`endif
    end else if (accept) begin
      state <= SHIFT;
      shreg <= bus.din >> 1;
      cnt <= '0;
      sdo_r <= bus.din[0];
      valid_r <= 1'b1;
      sof_r <= 1'b1;
      done_r <= 1'b0;
      ready_r <= 1'b0;
`ifdef PISO_PARITY_EN
      par <= ^bus.din;
`endif
    end else if (state == SHIFT && !last) begin
      shreg <= shreg >> 1;
      cnt <= cnt + 1'b1;
`ifdef PISO_PARITY_EN
      sdo_r <= cnt == CW'(WIDTH - 1) ? par : shreg[0];
`else
      sdo_r <= shreg[0];
`endif
      sof_r <= 1'b0;
      done_r <= cnt == CW'(N - 2);
      ready_r <= GAP_CYCLES == 0 && cnt == CW'(N - 2);
    end else if (state == SHIFT) begin
      state <= GAP_CYCLES > 0 ? GAP : IDLE;
      gcnt <= '0;
      sdo_r <= 1'b0;
      valid_r <= 1'b0;
      sof_r <= 1'b0;
      done_r <= 1'b0;
      ready_r <= GAP_CYCLES == 0;
    end else if (state == GAP) begin
      gcnt <= gcnt + 1'b1;
      state <= gcnt == 8'(GAP_CYCLES - 1) ? IDLE : GAP;
      ready_r <= gcnt == 8'(GAP_CYCLES - 1);
    end
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: checks a streaming and a gapped serializer against a frame-timeline model
module tb_piso_serializer;
  localparam int W = 4;
`ifdef PISO_PARITY_EN
  localparam int N = W + 1;
`else
  localparam int N = W;
`endif
  localparam int T = 4096;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic din_valid = 1'b0;
  logic [W-1:0] din = '0;
  logic [3:0] q = '0;
  int vectors = 0;
  int errors = 0;
  int cyc = 0;
  int fe[2];
  int gap[2] = '{0, 3};
  bit ev[2][T];
  bit ed[2][T];
  bit es[2][T];
  bit edn[2][T];
  piso_serializer_if #(.WIDTH(W)) bus0 ();
  piso_serializer_if #(.WIDTH(W)) bus1 ();
  assign bus0.din = din;
  assign bus0.din_valid = din_valid;
  assign bus1.din = din;
  assign bus1.din_valid = din_valid;
  piso_serializer #(.WIDTH(W), .GAP_CYCLES(0)) dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0.slave));
  piso_serializer #(.WIDTH(W), .GAP_CYCLES(3)) dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1.slave));
  always #5 clk = ~clk;
  function automatic bit rdy(input int i, input int t);
    return gap[i] == 0 ? t >= fe[i] : t > fe[i] + gap[i];
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask
  task automatic load(input int i, input int c, input logic [W-1:0] w);
    for (int k = 0; k < N; k++) begin
      int t;
      t = c + 1 + k;
      if (t < T) begin
        ev[i][t] = 1'b1;
        ed[i][t] = k < W ? w[k] : ^w;
        es[i][t] = k == 0;
        edn[i][t] = k == N - 1;
      end
    end
    fe[i] = c + N;
  endtask
  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int t = cyc; t < T; t++) begin
        ev[i][t] = 1'b0;
        ed[i][t] = 1'b0;
        es[i][t] = 1'b0;
        edn[i][t] = 1'b0;
      end
      fe[i] = -100;
    end
  endtask
  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      logic [4:0] o;
      o = i == 0 ? {bus0.sdo, bus0.sdo_valid, bus0.sof, bus0.done, bus0.din_ready}
                 : {bus1.sdo, bus1.sdo_valid, bus1.sof, bus1.done, bus1.din_ready};
      chk($sformatf("dut%0d.sdo", i), 32'(o[4]), 32'(ed[i][cyc] & ev[i][cyc]));
      chk($sformatf("dut%0d.sdo_valid", i), 32'(o[3]), 32'(ev[i][cyc]));
      chk($sformatf("dut%0d.sof", i), 32'(o[2]), 32'(es[i][cyc]));
      chk($sformatf("dut%0d.done", i), 32'(o[1]), 32'(edn[i][cyc]));
      chk($sformatf("dut%0d.din_ready", i), 32'(o[0]), 32'(rdy(i, cyc)));
    end
    if (bus0.sdo_valid === 1'b1) q = {bus0.sdo, q[3:1]};
  endtask
  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 2; i++)
      if (reset_n && din_valid && rdy(i, cyc)) load(i, cyc, din);
    cyc++;
    @(negedge clk);
    check_all();
  endtask
  initial begin
    fe[0] = -100;
    fe[1] = -100;
    @(negedge clk);
    check_all();
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    din = 4'b1011;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    repeat (4) tick();
    chk("sipo_q", 32'(q), 32'hB);
    repeat (8) tick();
    din = 4'hA;
    din_valid = 1'b1;
    tick();
    din = 4'h5;
    repeat (12) tick();
    din_valid = 1'b0;
    repeat (12) tick();
    din = 4'h9;
    din_valid = 1'b1;
    tick();
    din = 4'h6;
    repeat (10) tick();
    din_valid = 1'b0;
    repeat (12) tick();
    din = 4'hC;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    repeat (N + 8) begin
      din = W'($urandom);
      tick();
    end
    repeat (4) tick();
    din = 4'hF;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    repeat (3) tick();
    #2 reset_n = 1'b0;
    model_reset();
    #1 check_all();
    tick();
    reset_n = 1'b1;
    din = 4'h3;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    repeat (N + 8) tick();
    din = 4'b0111;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    repeat (N + 8) tick();
    repeat (400) begin
      din = W'($urandom);
      din_valid = $urandom_range(0, 3) != 0;
      tick();
    end
    din_valid = 1'b0;
    repeat (12) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
